// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the IF stage: bubble encoding, reset PC,
// PC increment and the buffered-word record type.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  // Instructions are word aligned; low two address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// Two-entry FIFO of fetched words. Push and pop may happen in the same cycle;
// flush empties it and overrides a simultaneous push.
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_word_t din,
  output fetch_word_t head,
  output logic [1:0]  count
);

  fetch_word_t entry [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  // Storage: each slot captures the incoming word when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst && !flush && push && (wr_ptr_q == 1'(gi))) begin
        entry[gi] <= din;
      end
    end
  end

  // Pointers and occupancy; flush and reset both return to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // The fetch issue rule keeps count+inflight <= 2, so overflow and underflow are impossible.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && (count_q == 2'd2)));
      assert (!(pop && (count_q == 2'd0)));
    end
  end

  assign head  = entry[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues reads to a synchronous instruction memory,
// buffers returned words across ID stalls and drives the IF/ID register.
// Redirects from MEM flush everything in flight (fixed 2-bubble penalty).
// Optional FETCH_PERF_CNT_EN adds saturating fetch/flush performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        IFID_Instr,
  output logic [31:0]        IFID_PC,
  output logic               IFID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_f2_q;     // PC of the read currently in flight
  logic        inflight_q;
  logic [1:0]  count;
  fetch_word_t head;
  fetch_word_t ret_word;
  logic        issue;
  logic        push;
  logic        pop;
  logic        load_valid;

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign ret_word  = '{instr: imem_rdata, pc: pc_f2_q};

  // A new read only goes out if both the buffer and the in-flight slot can absorb it.
  assign issue = !redirect_valid && (({1'b0, count} + {2'b00, inflight_q}) < 3'd2);
  // Buffer head always has priority so program order is kept.
  assign pop   = !redirect_valid && !stall && (count != 2'd0);
  // Returning word goes to the buffer whenever it cannot bypass straight into IF/ID.
  assign push  = !redirect_valid && inflight_q && (stall || (count != 2'd0));
  assign load_valid = !redirect_valid && !stall && ((count != 2'd0) || inflight_q);

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (ret_word),
    .head  (head),
    .count (count)
  );

  // PC and in-flight tracking; a redirect kills the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_f2_q    <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) pc_f2_q <= pc_q;
      if (redirect_valid) pc_q <= align_pc(redirect_target);
      else if (issue)     pc_q <= pc_q + PC_INC;
    end
  end

  // IF/ID register: buffer head, else bypassed return, else bubble (PC kept).
  always_ff @(posedge clk) begin
    if (rst) begin
      IFID_Valid <= 1'b0;
      IFID_Instr <= NOP_INSTR;
      IFID_PC    <= RESET_PC;
    end else if (redirect_valid) begin
      IFID_Valid <= 1'b0;
      IFID_Instr <= NOP_INSTR;
    end else if (!stall) begin
      if (count != 2'd0) begin
        IFID_Valid <= 1'b1;
        IFID_Instr <= head.instr;
        IFID_PC    <= head.pc;
      end else if (inflight_q) begin
        IFID_Valid <= 1'b1;
        IFID_Instr <= ret_word.instr;
        IFID_PC    <= ret_word.pc;
      end else begin
        IFID_Valid <= 1'b0;
        IFID_Instr <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: valid IF/ID loads and redirect cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      if (load_valid && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule
